aes_blk_feeder: RTL and testbench
=================================

// Module: aes_blk_feeder
// PURPOSE
//  Upstream/downstream adapter around the AES core. Packs a 32-bit valid/ready word stream into 128-bit blocks.
//  Drives the core's kld/ld/key/text_in/mode, captures text_out on done, and re-serialises results to 32-bit words.
//  Sits between the bus-side FIFO and the AES core.
// PARAMETERS
//  WORD_W        32  stream word width (BLK_W/WORD_W = 4 words per block)
//  BLK_W         128 AES block/key width
//  KEY_SETUP     10  cycles waited after core_kld before first core_ld (key expansion)
//  DONE_TIMEOUT  64  max cycles in S_WAIT before abort
// PORTS
//  clk            in   1    clock
//  rst            in   1    async reset, active-high
//  key_in         in   128  key; sampled when key_valid && key_ready
//  key_valid      in   1    key offer
//  key_ready      out  1    high only in S_FILL with word count 0
//  mode_in        in   1    0=decrypt, 1=encrypt; sampled with first word of each block
//  s_data         in   32   input word, first word = block bits [127:96]
//  s_valid        in   1    input word valid
//  s_ready        out  1    input word ready
//  m_data         out  32   output word, first word = result bits [127:96]
//  m_valid        out  1    output word valid
//  m_ready        in   1    output word ready
//  core_kld       out  1    one-cycle key-load pulse
//  core_ld        out  1    one-cycle block-load pulse
//  core_key       out  128  registered key, stable between kld events
//  core_text_in   out  128  registered block, stable from ld until capture
//  core_mode      out  1    registered mode
//  core_done      in   1    core result valid (level or pulse)
//  core_text_out  in   128  core result
//  busy           out  1    state != S_FILL or word count != 0
//  timeout_err    out  1    sticky; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs and registers 0; state S_FILL; key_loaded=0; IV reg 0.
//  States and transitions:
//   S_FILL:  s_ready=1 while cnt<4. Each s_valid&&s_ready shifts the word in, cnt++.
//            Key accept (cnt==0 only) -> core_kld=1 next cycle, key_loaded=1 -> S_KEY.
//            Key accept has priority over s_data in the same cycle; s_ready=0 that cycle.
//            cnt==4 && key_loaded -> S_LOAD. If cnt==4 && !key_loaded: hold, s_ready=0.
//   S_KEY:   count KEY_SETUP cycles, s_ready=0 -> S_FILL.
//   S_LOAD:  core_ld=1 for exactly one cycle -> S_WAIT, timer=0.
//   S_WAIT:  first cycle core_done=1 -> capture result, -> S_DRAIN.
//            timer==DONE_TIMEOUT-1 with no done -> timeout_err=1, block discarded, cnt=0 -> S_FILL.
//   S_DRAIN: m_valid=1, m_data = current word, held stable until m_ready.
//            4th handshake -> cnt=0 -> S_FILL.
//  core_done outside S_WAIT is ignored; a done in the same cycle as ld is not counted.
//  Latency: last input word accepted -> core_ld 1 cycle later; core_done -> m_valid 1 cycle later.
//  No overlap: next block is not accepted until the previous result is fully drained.
//  rst mid-operation: immediate return to reset state; partial blocks and results are lost; core must be reset by the same rst.
// CONFIGURATION
//  AES_CBC_EN defined:
//   Extra ports iv_in (in 128) and iv_valid (in 1); IV accepted under the same conditions and priority as key_in.
//   Decrypt: result = core_text_out ^ chain; chain <= ciphertext block (core_text_in).
//   Encrypt: core_text_in = plaintext ^ chain; chain <= core_text_out.
//   Chain reg = IV until first block completes.
//  AES_CBC_EN undefined: ECB only, result = core_text_out; no IV ports or chain reg.
// STRUCTURE
//  aes_pkg: WORD_W, BLK_W, WORDS_PER_BLK, typedef enum feeder_state_t {S_FILL,S_KEY,S_LOAD,S_WAIT,S_DRAIN}.
//  One sub-module: aes_blk_unpack (128->32 drain shifter with valid/ready, 2-bit word count).
// TESTING
//  1 ECB decrypt: key 000102..0e0f, words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, mode 0
//    -> m_data 00112233,44556677,8899aabb,ccddeeff; core_ld exactly one pulse.
//  2 Blocks before key: 4 words then key -> s_ready low after word 4, key_ready low (cnt!=0)
//    -> stall until rst; then key first -> correct output.
//  3 Back-pressure: m_ready toggled 1-in-3 -> m_data stable while m_valid&&!m_ready;
//    s_ready=0 until drain completes.
//  4 Timeout: core model never asserts done -> timeout_err=1 exactly DONE_TIMEOUT cycles after ld; back to S_FILL.
//  5 rst asserted in S_WAIT and in S_DRAIN -> all outputs 0 same cycle; next block processes normally.
//  6 AES_CBC_EN: IV 000102..0f, two ciphertext blocks -> block 2 result XORed with block-1 ciphertext;
//    compare to software model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared widths and FSM encoding for the AES block feeder.
package aes_pkg;
  localparam int WORD_W        = 32;
  localparam int BLK_W         = 128;
  localparam int WORDS_PER_BLK = BLK_W / WORD_W;

  typedef enum logic [2:0] {
    S_FILL,
    S_KEY,
    S_LOAD,
    S_WAIT,
    S_DRAIN
  } feeder_state_t;
endpackage

// File: rtl/aes_blk_unpack.sv
// 128->32 drain shifter: loads a result block and presents it MSW first on a valid/ready port.
module aes_blk_unpack
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BLK_W-1:0]  blk,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              last
);
  logic [BLK_W-1:0] sh;
  logic [1:0]       wcnt;

  assign m_data = sh[BLK_W-1 -: WORD_W];
  assign last   = m_valid && m_ready && (wcnt == 2'(WORDS_PER_BLK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      wcnt    <= '0;
      m_valid <= 1'b0;
    end else if (load) begin
      sh      <= blk;
      wcnt    <= '0;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      sh   <= {sh[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
      wcnt <= wcnt + 2'd1;
      if (last) m_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/aes_blk_feeder.sv
// Word-stream <-> AES core adapter: packs 4x32 into a block, drives kld/ld, drains the result.
// Define AES_CBC_EN to add the IV ports and CBC chaining; default build is ECB only.
module aes_blk_feeder
  import aes_pkg::*;
#(
  parameter int KEY_SETUP    = 10,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
`ifdef AES_CBC_EN
  input  logic [BLK_W-1:0]  iv_in,
  input  logic              iv_valid,
`endif
  input  logic [BLK_W-1:0]  key_in,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              mode_in,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              core_kld,
  output logic              core_ld,
  output logic [BLK_W-1:0]  core_key,
  output logic [BLK_W-1:0]  core_text_in,
  output logic              core_mode,
  input  logic              core_done,
  input  logic [BLK_W-1:0]  core_text_out,
  output logic              busy,
  output logic              timeout_err
);
  localparam int TMR_W = $clog2((KEY_SETUP > DONE_TIMEOUT ? KEY_SETUP : DONE_TIMEOUT) + 1);
  localparam logic [2:0] FULL = 3'(WORDS_PER_BLK);

  feeder_state_t    state, state_nxt;
  logic [2:0]       cnt;
  logic [BLK_W-1:0] blk, blk_nxt;
  logic [TMR_W-1:0] timer;
  logic             key_loaded;
  logic             side_req, key_acc, s_fire, blk_full, cap, tmo, drain_last;
  logic [BLK_W-1:0] pre_mask, post_mask;

  assign key_ready = (state == S_FILL) && (cnt == 3'd0);
  assign key_acc   = key_valid && key_ready;
  // Key/IV offers win over data in the cnt==0 slot, so data is refused that cycle.
  assign s_ready   = (state == S_FILL) && (cnt < FULL) && !(key_ready && side_req);
  assign s_fire    = s_valid && s_ready;
  assign blk_nxt   = s_fire ? {blk[BLK_W-WORD_W-1:0], s_data} : blk;
  assign blk_full  = (cnt == FULL) || ((cnt == FULL - 3'd1) && s_fire);
  assign core_ld   = (state == S_LOAD);
  assign cap       = (state == S_WAIT) && core_done;
  assign tmo       = (state == S_WAIT) && !core_done && (timer == TMR_W'(DONE_TIMEOUT - 1));
  assign busy      = (state != S_FILL) || (cnt != 3'd0);

`ifdef AES_CBC_EN
  logic [BLK_W-1:0] chain;
  assign side_req  = key_valid || iv_valid;
  assign pre_mask  = core_mode ? chain : '0;
  assign post_mask = core_mode ? '0 : chain;

  // Encrypt chains on the core output, decrypt on the ciphertext that went in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        chain <= '0;
    else if (iv_valid && key_ready) chain <= iv_in;
    else if (cap)                   chain <= core_mode ? core_text_out : core_text_in;
  end
`else
  assign side_req  = key_valid;
  assign pre_mask  = '0;
  assign post_mask = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (key_acc) state_nxt = S_KEY;
               else if (blk_full && key_loaded) state_nxt = S_LOAD;
      S_KEY:   if (timer == TMR_W'(KEY_SETUP - 1)) state_nxt = S_FILL;
      S_LOAD:  state_nxt = S_WAIT;
      S_WAIT:  if (core_done) state_nxt = S_DRAIN;
               else if (tmo) state_nxt = S_FILL;
      S_DRAIN: if (drain_last) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      blk          <= '0;
      timer        <= '0;
      key_loaded   <= 1'b0;
      core_kld     <= 1'b0;
      core_key     <= '0;
      core_mode    <= 1'b0;
      core_text_in <= '0;
      timeout_err  <= 1'b0;
    end else begin
      core_kld <= key_acc;
      if (key_acc) begin
        core_key   <= key_in;
        key_loaded <= 1'b1;
      end
      if (tmo || drain_last) cnt <= '0;
      else if (s_fire)       cnt <= cnt + 3'd1;
      blk <= blk_nxt;
      if (s_fire && cnt == 3'd0) core_mode <= mode_in;
      if (state == S_FILL && state_nxt == S_LOAD) core_text_in <= blk_nxt ^ pre_mask;
      if (tmo) timeout_err <= 1'b1;
      // timer restarts at 0 on every entry to S_KEY / S_WAIT
      if ((state == S_KEY || state == S_WAIT) && state_nxt == state) timer <= timer + TMR_W'(1);
      else                                                            timer <= '0;
    end
  end

  aes_blk_unpack u_unpack (
    .clk     (clk),
    .rst     (rst),
    .load    (cap),
    .blk     (core_text_out ^ post_mask),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .last    (drain_last)
  );
endmodule

// File: tb/tb_aes_blk_feeder.sv
// Directed bench for aes_blk_feeder with a stub AES core (fixed 2-cycle done, known-answer table).
module tb_aes_blk_feeder;
  import aes_pkg::*;

  localparam int TMO = 64;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 0, rst = 1;
  logic [127:0] key_in, core_key, core_text_in, core_text_out = '0;
  logic         key_valid, key_ready, mode_in, s_valid, s_ready, m_valid, m_ready;
  logic [31:0]  s_data, m_data;
  logic         core_kld, core_ld, core_mode, core_done, busy, timeout_err;
  logic         mdl_done = 0, stray = 0;
  bit           never_done = 0;
  int           n_tests = 0, n_fail = 0, ld_cnt = 0, kld_cnt = 0;
`ifdef AES_CBC_EN
  logic [127:0] iv_in;
  logic         iv_valid;
`endif

  assign core_done = mdl_done | stray;

  aes_blk_feeder #(.KEY_SETUP(10), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
`ifdef AES_CBC_EN
    .iv_in(iv_in), .iv_valid(iv_valid),
`endif
    .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready), .mode_in(mode_in),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .core_kld(core_kld), .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
    .core_mode(core_mode), .core_done(core_done), .core_text_out(core_text_out),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Stub core: the FIPS-197 pair decrypts exactly, anything else is a trivial reversible mix.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t, input logic m);
    if (!m && k == K1 && t == C1) return P1;
    return m ? (t ^ k) : ~(t ^ k);
  endfunction

  logic [127:0] mk, mt;
  logic         mm;
  int           dly = 0;
  bit           pend = 0;
  always @(negedge clk) begin
    if (rst) begin
      pend = 0; mdl_done = 0;
    end else begin
      mdl_done = 0;
      if (core_ld) begin
        pend = 1; dly = 2; mk = core_key; mt = core_text_in; mm = core_mode; ld_cnt++;
      end else if (pend) begin
        dly--;
        if (dly == 0) begin
          pend = 0;
          if (!never_done) begin mdl_done = 1; core_text_out = core_fn(mk, mt, mm); end
        end
      end
      if (core_kld) kld_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] iv);
    bit ok = 0;
    key_in = k; key_valid = 1;
`ifdef AES_CBC_EN
    iv_in = iv; iv_valid = 1;
`else
    if (iv != '0) $display("note: IV ignored in ECB build");
`endif
    for (int i = 0; i < 100; i++) begin
      if (key_ready) begin tick; ok = 1; break; end
      tick;
    end
    key_valid = 0;
`ifdef AES_CBC_EN
    iv_valid = 0;
`endif
    chk("key_accept", 128'(ok), 128'd1);
    chk("kld_pulse", 128'(core_kld), 128'd1);
    chk("core_key", core_key, k);
  endtask

  task automatic send_word(input logic [31:0] w, input logic m);
    bit ok = 0;
    s_data = w; s_valid = 1; mode_in = m;
    for (int i = 0; i < 100; i++) begin
      if (s_ready) begin tick; ok = 1; break; end
      tick;
    end
    s_valid = 0;
    if (!ok) chk("word_accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic send_blk(input logic [127:0] words, input logic m);
    for (int w = 0; w < 4; w++) send_word(words[127-32*w -: 32], m);
  endtask

  task automatic drain(input logic [127:0] exp, input bit bp, input string nm);
    int k = 0, cyc = 0;
    bit stall = 0;
    logic [31:0] held = '0;
    while (k < 4 && cyc < 300) begin
      m_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (m_valid) begin
        if (stall) chk({nm, "_stable"}, 128'(m_data), 128'(held));
        if (m_ready) begin
          chk($sformatf("%s_w%0d", nm, k), 128'(m_data), 128'(exp[127-32*k -: 32]));
          k++; stall = 0;
        end else begin
          held = m_data; stall = 1;
          if (bp) chk({nm, "_s_ready_drain"}, 128'(s_ready), 128'd0);
        end
      end
      tick; cyc++;
    end
    m_ready = 0;
    if (k < 4) chk({nm, "_drain_timeout"}, 128'(k), 128'd4);
  endtask

  task automatic do_block(input logic [127:0] k, input logic [127:0] words, input logic m,
                          input logic [127:0] exp, input bit bp, input string nm);
    int ld0;
    ld0 = ld_cnt;
    load_key(k, '0);
    send_blk(words, m);
    chk({nm, "_ld_latency"}, 128'(core_ld), 128'd1);
    tick; tick;
    chk({nm, "_mvalid_early"}, 128'(m_valid), 128'd0);
    tick;
    chk({nm, "_mvalid_after_done"}, 128'(m_valid), 128'd1);
    drain(exp, bp, nm);
    chk({nm, "_ld_count"}, 128'(ld_cnt - ld0), 128'd1);
    chk({nm, "_idle"}, 128'(busy), 128'd0);
  endtask

  task automatic pulse_rst(input string nm);
    rst = 1; #1;
    chk({nm, "_m_valid"}, 128'(m_valid), 128'd0);
    chk({nm, "_busy"}, 128'(busy), 128'd0);
    chk({nm, "_ld_kld"}, 128'({core_ld, core_kld}), 128'd0);
    chk({nm, "_core_regs"}, core_key | core_text_in | 128'(core_mode), 128'd0);
    chk({nm, "_timeout_err"}, 128'(timeout_err), 128'd0);
    tick; tick;
    rst = 0;
    tick;
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] words;
    logic         mode;
    logic [127:0] exp;
    string        nm;
  } vec_t;
  vec_t vt[4];

  initial begin
    int ld0, kld0;
    key_in = '0; key_valid = 0; mode_in = 0; s_data = '0; s_valid = 0; m_ready = 0;
`ifdef AES_CBC_EN
    iv_in = '0; iv_valid = 0;
`endif
    vt[0] = '{K1, C1, 1'b0, P1, "ecb_fips_dec"};
    vt[1] = '{'0, 128'h0123456789abcdeffedcba9876543210, 1'b1,
              128'h0123456789abcdeffedcba9876543210, "enc_zero_key"};
    vt[2] = '{'1, 128'hdeadbeefcafef00d123456780badc0de, 1'b1,
              128'h2152411035010ff2edcba987f4523f21, "enc_ones_key"};
    vt[3] = '{'0, 128'h00000000ffffffffa5a5a5a50f0f0f0f, 1'b0,
              128'hffffffff000000005a5a5a5af0f0f0f0, "dec_zero_key"};

    repeat (2) @(posedge clk); #1;
    chk("rst_outputs", 128'({m_valid, core_kld, core_ld, busy, timeout_err, core_mode}), 128'd0);
    chk("rst_core_regs", core_key | core_text_in, 128'd0);
    rst = 0; tick;
    chk("rst_ready", 128'({key_ready, s_ready}), 128'b11);
    chk("rst_busy", 128'(busy), 128'd0);

    // stray done while idle must not start a drain
    stray = 1; tick; stray = 0; tick;
    chk("stray_done_ignored", 128'(m_valid), 128'd0);

    // table: known-answer decrypt plus three stub transforms, each with its own key load
    foreach (vt[i]) do_block(vt[i].key, vt[i].words, vt[i].mode, vt[i].exp, 1'b0, vt[i].nm);

    // back-pressure: m_ready high one cycle in three
    do_block('0, 128'h11112222333344445555666677778888, 1'b1,
             128'h11112222333344445555666677778888, 1'b1, "backpressure");

    // timeout: core never answers; TMO full S_WAIT cycles elapse after the ld cycle
    never_done = 1;
    load_key(K1, '0);
    send_blk(C1, 1'b0);
    chk("tmo_ld", 128'(core_ld), 128'd1);
    repeat (TMO) tick;
    chk("tmo_not_early", 128'(timeout_err), 128'd0);
    tick;
    chk("tmo_set", 128'(timeout_err), 128'd1);
    chk("tmo_back_to_fill", 128'({busy, key_ready}), 128'b01);
    never_done = 0;
    repeat (5) tick;
    chk("tmo_sticky", 128'(timeout_err), 128'd1);

    // reset while waiting on the core
    load_key(K1, '0);
    send_blk(C1, 1'b0);
    tick;
    chk("wait_busy", 128'(busy), 128'd1);
    pulse_rst("rst_in_wait");
    repeat (4) tick;
    chk("rst_wait_no_result", 128'(m_valid), 128'd0);

    // reset mid-drain, after one word has gone out
    load_key(vt[1].key, '0);
    send_blk(vt[1].words, vt[1].mode);
    for (int i = 0; i < 20 && !m_valid; i++) tick;
    chk("drain_started", 128'(m_valid), 128'd1);
    m_ready = 1; tick; m_ready = 0;
    pulse_rst("rst_in_drain");
    do_block(vt[2].key, vt[2].words, vt[2].mode, vt[2].exp, 1'b0, "after_rst");

    // block before key: stalls until reset, key offers refused while words are held
    pulse_rst("pre_key_rst");
    kld0 = kld_cnt; ld0 = ld_cnt;
    send_blk(C1, 1'b0);
    chk("nokey_s_ready", 128'(s_ready), 128'd0);
    chk("nokey_key_ready", 128'(key_ready), 128'd0);
    chk("nokey_busy", 128'(busy), 128'd1);
    key_in = K1; key_valid = 1;
    repeat (12) tick;
    key_valid = 0;
    chk("nokey_no_kld", 128'(kld_cnt - kld0), 128'd0);
    chk("nokey_no_ld", 128'(ld_cnt - ld0), 128'd0);
    pulse_rst("nokey_rst");
    do_block(K1, C1, 1'b0, P1, 1'b0, "key_then_block");

`ifdef AES_CBC_EN
    begin
      logic [127:0] iv, k2, ca, cb;
      iv = 128'h000102030405060708090a0b0c0d0e0f;
      k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      ca = 128'h7649abac8119b246cee98e9b12e9197d;
      cb = 128'h5086cb9b507219ee95db113a917678b2;
      load_key(k2, iv);
      send_blk(ca, 1'b0);
      drain(core_fn(k2, ca, 1'b0) ^ iv, 1'b0, "cbc_blk1");
      send_blk(cb, 1'b0);
      drain(core_fn(k2, cb, 1'b0) ^ ca, 1'b0, "cbc_blk2");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
